// File: rtl/bw_r_frf_arb.sv
// bw_r_frf_arb: arbitrates the shared FRF R/W port between load writeback, FPU writeback and reads,
// with starvation promotion for the lower-priority requesters and a 2-cycle tagged read return.
module bw_r_frf_arb #(
    parameter int TAG_W      = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic             rclk,
    input  logic             rst_l,
    input  logic             ld_req,
    input  logic [6:0]       ld_addr,
    input  logic [1:0]       ld_wen,
    input  logic [77:0]      ld_data,
    output logic             ld_gnt,
    input  logic             fw_req,
    input  logic [6:0]       fw_addr,
    input  logic [1:0]       fw_wen,
    input  logic [77:0]      fw_data,
    output logic             fw_gnt,
    input  logic             rd_req,
    input  logic [6:0]       rd_addr,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_gnt,
    output logic [1:0]       ctl_frf_wen,
    output logic             ctl_frf_ren,
    output logic [6:0]       ctl_frf_addr,
    output logic [77:0]      dp_frf_data,
    input  logic [77:0]      frf_dp_data,
    output logic             rd_rtn_vld,
    output logic [TAG_W-1:0] rd_rtn_tag,
    output logic [77:0]      rd_rtn_data
);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [3:0]       rd_cnt, fw_cnt;
    logic             v1, v2;
    logic [TAG_W-1:0] t1, t2;
    logic             rd_win, fw_win;

    always_comb begin
        // a saturated rd beats everything; a saturated fw only beats ld
        rd_win       = rd_req && rd_cnt == LIM;
        fw_win       = fw_req && fw_cnt == LIM && !rd_win;
        rd_gnt       = rst_l && (rd_win || (rd_req && !ld_req && !fw_req));
        fw_gnt       = rst_l && !rd_win && fw_req && (fw_win || !ld_req);
        ld_gnt       = rst_l && ld_req && !rd_win && !fw_win;
        ctl_frf_wen  = ld_gnt ? ld_wen : fw_gnt ? fw_wen : 2'b00;
        ctl_frf_ren  = rd_gnt;
        ctl_frf_addr = ld_gnt ? ld_addr : fw_gnt ? fw_addr : rd_gnt ? rd_addr : 7'd0;
        dp_frf_data  = ld_gnt ? ld_data : fw_gnt ? fw_data : 78'd0;
        rd_rtn_vld   = v2;
        rd_rtn_tag   = t2;
        rd_rtn_data  = v2 ? frf_dp_data : 78'd0;
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            rd_cnt <= '0;
            fw_cnt <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            t1     <= '0;
            t2     <= '0;
        end else begin
            rd_cnt <= (!rd_req || rd_gnt) ? 4'd0 : (rd_cnt == LIM) ? rd_cnt : rd_cnt + 4'd1;
            fw_cnt <= (!fw_req || fw_gnt) ? 4'd0 : (fw_cnt == LIM) ? fw_cnt : fw_cnt + 4'd1;
            v1     <= rd_gnt;
            t1     <= rd_tag;
            v2     <= v1;
            t2     <= t1;
        end
    end
endmodule

// File: tb/tb_bw_r_frf_arb.sv
// tb_bw_r_frf_arb: directed vector table, hand sequences and a randomized run against a
// behavioural arbitration/FRF model for bw_r_frf_arb.
module tb_bw_r_frf_arb;
    localparam int TAG_W = 4;
    localparam int LIM   = 4;

    logic        rclk = 1'b0;
    logic        rst_l = 1'b0;
    logic        ld_req = 1'b0, fw_req = 1'b0, rd_req = 1'b0;
    logic [6:0]  ld_addr = '0, fw_addr = '0, rd_addr = '0;
    logic [1:0]  ld_wen = '0, fw_wen = '0;
    logic [77:0] ld_data = '0, fw_data = '0;
    logic [3:0]  rd_tag = '0;
    logic        ld_gnt, fw_gnt, rd_gnt, ctl_frf_ren, rd_rtn_vld;
    logic [1:0]  ctl_frf_wen;
    logic [6:0]  ctl_frf_addr;
    logic [77:0] dp_frf_data, rd_rtn_data;
    logic [77:0] frf_dp_data = '0;
    logic [3:0]  rd_rtn_tag;

    always #5 rclk = ~rclk;

    bw_r_frf_arb #(.TAG_W(TAG_W), .STARVE_LIM(LIM)) dut (
        .rclk(rclk), .rst_l(rst_l),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wen(ld_wen), .ld_data(ld_data), .ld_gnt(ld_gnt),
        .fw_req(fw_req), .fw_addr(fw_addr), .fw_wen(fw_wen), .fw_data(fw_data), .fw_gnt(fw_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_gnt(rd_gnt),
        .ctl_frf_wen(ctl_frf_wen), .ctl_frf_ren(ctl_frf_ren), .ctl_frf_addr(ctl_frf_addr),
        .dp_frf_data(dp_frf_data), .frf_dp_data(frf_dp_data),
        .rd_rtn_vld(rd_rtn_vld), .rd_rtn_tag(rd_rtn_tag), .rd_rtn_data(rd_rtn_data)
    );

    // FRF array model: half-word writes, 2-cycle read latency
    logic [77:0] mem [128];
    logic [77:0] r1 = '0;
    initial for (int i = 0; i < 128; i++) mem[i] = '0;
    always @(posedge rclk) begin
        if (ctl_frf_ren) r1 <= mem[ctl_frf_addr];
        frf_dp_data <= r1;
        if (ctl_frf_wen[0]) mem[ctl_frf_addr][38:0] <= dp_frf_data[38:0];
        if (ctl_frf_wen[1]) mem[ctl_frf_addr][77:39] <= dp_frf_data[77:39];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, ld;
        logic [1:0] lw;
        logic       fw;
        logic [1:0] fwn;
        logic       rd, e_ld, e_fw, e_rd;
        logic [1:0] e_wen;
        logic       e_ren;
        logic [6:0] e_addr;
        logic       e_vld;
        logic [3:0] e_tag;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic rst, logic ld, logic [1:0] lw, logic fw, logic [1:0] fwn, logic rd,
                                logic e_ld, logic e_fw, logic e_rd, logic [1:0] e_wen, logic e_ren,
                                logic [6:0] e_addr, logic e_vld, logic [3:0] e_tag);
        vec_t v;
        v = '{rst, ld, lw, fw, fwn, rd, e_ld, e_fw, e_rd, e_wen, e_ren, e_addr, e_vld, e_tag};
        tbl.push_back(v);
    endfunction

    localparam logic [77:0] LD_D = 78'h1234;
    localparam logic [77:0] FW_D = 78'h5678;

    task automatic step;
        @(posedge rclk);
        #1;
    endtask

    typedef struct { int due; logic [3:0] tag; logic [77:0] data; } rt_t;
    rt_t         q[$];
    logic [77:0] shadow [128];

    initial begin
        // reset state / reset forces grants off
        add(0,1,2'b11,1,2'b01,1, 0,0,0,2'b00,0,7'h00,0,4'h0);
        add(0,1,2'b11,1,2'b01,1, 0,0,0,2'b00,0,7'h00,0,4'h0);
        // priority: ld, then fw, then rd
        add(1,1,2'b11,1,2'b01,1, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,0,2'b11,1,2'b01,1, 0,1,0,2'b01,0,7'h09,0,4'h0);
        add(1,0,2'b11,0,2'b01,1, 0,0,1,2'b00,1,7'h05,0,4'h0);
        add(1,0,2'b11,0,2'b01,0, 0,0,0,2'b00,0,7'h00,0,4'h0);
        // read starvation under continuous ld
        add(1,1,2'b11,0,2'b01,1, 1,0,0,2'b11,0,7'h05,1,4'h4);
        add(1,1,2'b11,0,2'b01,1, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,1,2'b11,0,2'b01,1, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,1,2'b11,0,2'b01,1, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,1,2'b11,0,2'b01,1, 0,0,1,2'b00,1,7'h05,0,4'h0);
        add(1,1,2'b11,0,2'b01,0, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,0,2'b11,0,2'b01,0, 0,0,0,2'b00,0,7'h00,1,4'ha);
        // dual saturation: rd first, then fw, then ld resumes
        add(1,1,2'b11,1,2'b01,1, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,1,2'b11,1,2'b01,1, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,1,2'b11,1,2'b01,1, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,1,2'b11,1,2'b01,1, 1,0,0,2'b11,0,7'h05,0,4'h0);
        add(1,1,2'b11,1,2'b01,1, 0,0,1,2'b00,1,7'h05,0,4'h0);
        add(1,1,2'b11,1,2'b01,0, 0,1,0,2'b01,0,7'h09,0,4'h0);
        add(1,1,2'b11,0,2'b01,0, 1,0,0,2'b11,0,7'h05,1,4'h1);
        // half write, then zero-enable write
        add(1,1,2'b10,0,2'b01,0, 1,0,0,2'b10,0,7'h05,0,4'h0);
        add(1,1,2'b00,0,2'b01,0, 1,0,0,2'b00,0,7'h05,0,4'h0);
        add(1,0,2'b11,0,2'b01,0, 0,0,0,2'b00,0,7'h00,0,4'h0);

        ld_addr = 7'h05; fw_addr = 7'h09; rd_addr = 7'h05; ld_data = LD_D; fw_data = FW_D;
        rst_l = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst_l = tbl[i].rst; ld_req = tbl[i].ld; ld_wen = tbl[i].lw;
            fw_req = tbl[i].fw; fw_wen = tbl[i].fwn; rd_req = tbl[i].rd; rd_tag = 4'(i);
            #3;
            chk($sformatf("v%0d ld_gnt", i), 128'(ld_gnt), 128'(tbl[i].e_ld));
            chk($sformatf("v%0d fw_gnt", i), 128'(fw_gnt), 128'(tbl[i].e_fw));
            chk($sformatf("v%0d rd_gnt", i), 128'(rd_gnt), 128'(tbl[i].e_rd));
            chk($sformatf("v%0d wen", i), 128'(ctl_frf_wen), 128'(tbl[i].e_wen));
            chk($sformatf("v%0d ren", i), 128'(ctl_frf_ren), 128'(tbl[i].e_ren));
            chk($sformatf("v%0d addr", i), 128'(ctl_frf_addr), 128'(tbl[i].e_addr));
            chk($sformatf("v%0d wdata", i), 128'(dp_frf_data),
                128'(tbl[i].e_ld ? LD_D : tbl[i].e_fw ? FW_D : 78'd0));
            chk($sformatf("v%0d rtn_vld", i), 128'(rd_rtn_vld), 128'(tbl[i].e_vld));
            chk($sformatf("v%0d rtn_data", i), 128'(rd_rtn_data), 128'(tbl[i].e_vld ? LD_D : 78'd0));
            if (tbl[i].e_vld) chk($sformatf("v%0d rtn_tag", i), 128'(rd_rtn_tag), 128'(tbl[i].e_tag));
            step();
        end

        // back-to-back reads return on consecutive cycles
        ld_req = 0; fw_req = 0; rd_req = 1; rd_addr = 7'h09; rd_tag = 4'h2;
        #3 chk("b2b gnt0", 128'(rd_gnt), 128'(1));
        step();
        rd_addr = 7'h05; rd_tag = 4'h3;
        #3 chk("b2b gnt1", 128'(rd_gnt), 128'(1));
        step();
        rd_req = 0;
        #3 chk("b2b vld0", 128'(rd_rtn_vld), 128'(1));
        chk("b2b tag0", 128'(rd_rtn_tag), 128'(4'h2));
        chk("b2b data0", 128'(rd_rtn_data), 128'(FW_D));
        step();
        #3 chk("b2b vld1", 128'(rd_rtn_vld), 128'(1));
        chk("b2b tag1", 128'(rd_rtn_tag), 128'(4'h3));
        chk("b2b data1", 128'(rd_rtn_data), 128'(LD_D));
        step();
        #3 chk("b2b vld2", 128'(rd_rtn_vld), 128'(0));
        step();

        // reset mid-read drops the in-flight read
        rd_req = 1; rd_tag = 4'h7;
        #3 chk("rst rd_gnt", 128'(rd_gnt), 128'(1));
        step();
        rst_l = 0; ld_req = 1; fw_req = 1;
        #3 chk("rst gnts", 128'({ld_gnt, fw_gnt, rd_gnt}), 128'(0));
        chk("rst frf", 128'({ctl_frf_wen, ctl_frf_ren, ctl_frf_addr}), 128'(0));
        chk("rst wdata", 128'(dp_frf_data), 128'(0));
        step();
        ld_req = 0; fw_req = 0; rd_req = 0;
        #3 chk("rst vld", 128'(rd_rtn_vld), 128'(0));
        chk("rst rdata", 128'(rd_rtn_data), 128'(0));
        step();

        // randomized run against the behavioural model
        for (int i = 0; i < 128; i++) shadow[i] = '0;
        shadow[5] = LD_D;
        shadow[9] = FW_D;
        begin
            logic lp, fp, rp;
            int   rw, fwt, w;
            lp = 0; fp = 0; rp = 0; rw = 0; fwt = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (!lp && $urandom_range(0, 2) == 0) begin
                    lp = 1; ld_addr = 7'($urandom); ld_wen = 2'($urandom);
                    ld_data = 78'({$urandom, $urandom, $urandom});
                end
                if (!fp && $urandom_range(0, 2) == 0) begin
                    fp = 1; fw_addr = 7'($urandom); fw_wen = 2'($urandom);
                    fw_data = 78'({$urandom, $urandom, $urandom});
                end
                if (!rp && $urandom_range(0, 1) == 0) begin
                    rp = 1; rd_addr = 7'($urandom); rd_tag = 4'($urandom);
                end
                ld_req = lp; fw_req = fp; rd_req = rp;
                rst_l = (cyc != 0) && ($urandom_range(0, 149) != 0);
                // 0 none, 1 ld, 2 fw, 3 rd
                w = !rst_l ? 0 : (rp && rw >= LIM) ? 3 : (fp && fwt >= LIM) ? 2 :
                    lp ? 1 : fp ? 2 : rp ? 3 : 0;
                #3;
                chk("rnd ld_gnt", 128'(ld_gnt), 128'(w == 1));
                chk("rnd fw_gnt", 128'(fw_gnt), 128'(w == 2));
                chk("rnd rd_gnt", 128'(rd_gnt), 128'(w == 3));
                chk("rnd wen", 128'(ctl_frf_wen), 128'(w == 1 ? ld_wen : w == 2 ? fw_wen : 2'b00));
                chk("rnd ren", 128'(ctl_frf_ren), 128'(w == 3));
                chk("rnd addr", 128'(ctl_frf_addr),
                    128'(w == 1 ? ld_addr : w == 2 ? fw_addr : w == 3 ? rd_addr : 7'd0));
                chk("rnd wdata", 128'(dp_frf_data), 128'(w == 1 ? ld_data : w == 2 ? fw_data : 78'd0));
                if (q.size() > 0 && q[0].due == cyc) begin
                    chk("rnd rtn_vld", 128'(rd_rtn_vld), 128'(1));
                    chk("rnd rtn_tag", 128'(rd_rtn_tag), 128'(q[0].tag));
                    chk("rnd rtn_data", 128'(rd_rtn_data), 128'(q[0].data));
                    void'(q.pop_front());
                end else begin
                    chk("rnd rtn_vld", 128'(rd_rtn_vld), 128'(0));
                    chk("rnd rtn_data", 128'(rd_rtn_data), 128'(0));
                end
                if (w == 1) begin
                    if (ld_wen[0]) shadow[ld_addr][38:0] = ld_data[38:0];
                    if (ld_wen[1]) shadow[ld_addr][77:39] = ld_data[77:39];
                    lp = 0;
                end
                if (w == 2) begin
                    if (fw_wen[0]) shadow[fw_addr][38:0] = fw_data[38:0];
                    if (fw_wen[1]) shadow[fw_addr][77:39] = fw_data[77:39];
                    fp = 0;
                end
                if (w == 3) begin
                    q.push_back('{cyc + 2, rd_tag, shadow[rd_addr]});
                    rp = 0;
                end
                if (!rst_l) begin
                    rw = 0; fwt = 0; q.delete();
                end else begin
                    rw  = (rp && w != 3) ? ((rw + 1 > LIM) ? LIM : rw + 1) : 0;
                    fwt = (fp && w != 2) ? ((fwt + 1 > LIM) ? LIM : fwt + 1) : 0;
                end
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
